// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: IF-stage lookup, EX-stage
// resolve, flush control and statistics. The slave modport is the predictor
// and the master modport is the pipeline that drives it.
interface branch_predictor_if;
  logic        [63:0] if_pc;
  logic               pred_taken;
  logic        [63:0] pred_target;

  logic               ex_valid;
  logic               ex_is_branch;
  logic        [63:0] ex_pc;
  logic               ex_taken;
  logic        [63:0] ex_target;
  logic               ex_pred_taken;
  logic        [63:0] ex_pred_target;
  logic               mispredict;
  logic        [63:0] redirect_pc;

  logic               flush_req;
  logic               bp_busy;
  logic        [31:0] stat_branches;
  logic        [31:0] stat_mispredicts;

  modport slave (
    input  if_pc,
    output pred_taken, pred_target,
    input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output mispredict, redirect_pc,
    input  flush_req,
    output bp_busy, stat_branches, stat_mispredicts
  );

  modport master (
    output if_pc,
    input  pred_taken, pred_target,
    output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  mispredict, redirect_pc,
    output flush_req,
    input  bp_busy, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB.
// - Combinational lookup for the fetch PC from registered tables.
// - Combinational resolve (mispredict / redirect) for the EX-stage branch.
// - Training on the resolve edge; a two-state FSM sweeps the tables on flush.
// Optional feature: define BRANCH_PREDICTOR_STATS_EN to build saturating
// resolved-branch and mispredict counters; otherwise the stat outputs are 0.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int                IDX_W    = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  // Table storage: status bits (valid, counter) and payload (tag, target).
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [63:0]        target_q [ENTRIES];

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;

  // Lookup path.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign bus.bp_busy     = (state_q == CLEAR);
  assign bus.pred_taken  = if_hit && ctr_q[if_idx][1] && (state_q != CLEAR);
  assign bus.pred_target = bus.pred_taken ? target_q[if_idx] : bus.if_pc + 64'd4;

  // Resolve path.
  logic             resolve;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             train;

  assign resolve = bus.ex_valid && bus.ex_is_branch;
  assign ex_idx  = bus.ex_pc[IDX_W+1:2];
  assign ex_tag  = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bus.mispredict  = resolve &&
                           ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign bus.redirect_pc = (resolve && bus.ex_taken) ? bus.ex_target : bus.ex_pc + 64'd4;

  // Tables only learn while idle and not in the cycle a flush is accepted.
  assign train = resolve && (state_q == IDLE) && !bus.flush_req;

  // Clear-sweep FSM: a flush (even mid-sweep) restarts the sweep at entry 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (bus.flush_req) begin
            ptr_q <= '0;
          end else if (ptr_q == LAST_IDX) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Status bits: reset/sweep clearing plus counter training and allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (state_q == CLEAR) begin
      valid_q[ptr_q] <= 1'b0;
      ctr_q[ptr_q]   <= 2'b01;
    end else if (train) begin
      if (ex_hit) begin
        if (bus.ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (bus.ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Payload write on any trained taken branch (refresh on hit, fill on miss).
  // NOTE: tag/target are plain RAM with no reset; a cleared valid bit makes
  // their contents irrelevant, so they never need initialising.
  always_ff @(posedge clk) begin
    if (train && bus.ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= bus.ex_target;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  // Saturating statistics; a flush leaves them untouched, only rst zeroes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (resolve) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (bus.mispredict && (mispredicts_q != 32'hFFFF_FFFF))
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispredicts_q;
`else
  assign bus.stat_branches    = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with a direct-mapped branch target buffer (BTB). It sits in the IF stage and produces a taken/not-taken prediction and a target for every fetch PC. It also accepts resolved outcomes from the EX stage, where the branch condition evaluator and the target adder produce them. From those outcomes it flags mispredicts, supplies the redirect PC, and trains its tables.

## Interface
Parameters:
- ENTRIES, 64, number of BTB/counter entries; power of two, ≥4
- TAG_W, 10, stored PC tag bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  64  fetch PC
- pred_taken  out  1  predicted taken
- pred_target  out  64  predicted next PC
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  instruction is a conditional branch
- ex_pc  in  64  PC of the resolving branch
- ex_taken  in  1  resolved condition from the branch evaluator
- ex_target  in  64  resolved branch target
- ex_pred_taken  in  1  prediction carried down the pipe with this branch
- ex_pred_target  in  64  predicted target carried down the pipe
- mispredict  out  1  flush/redirect request
- redirect_pc  out  64  correct next PC
- flush_req  in  1  start a full table clear
- bp_busy  out  1  clear sweep in progress
- stat_branches  out  32  resolved branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Index = pc[IDX_W+1:2], where IDX_W = log2(ENTRIES). Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, a 64-bit target, and a 2-bit saturating counter.
- Lookup is combinational from the registered tables.
  - Hit = valid && tag match.
  - pred_taken = hit && ctr[1] && !bp_busy.
  - pred_target = pred_taken ? entry target : if_pc+4 (64-bit wrap).
- Resolve is combinational when ex_valid && ex_is_branch.
  - mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - When resolve is not active, mispredict=0 and redirect_pc=ex_pc+4.
- Training is applied at the clock edge on resolve.
  - Hit: counter increments on taken, saturating at 2'b11. It decrements on not-taken, saturating at 2'b00. Target is overwritten with ex_target on taken.
  - Miss and taken: allocate the entry. Set valid=1, write tag and target, counter=2'b10.
  - Miss and not-taken: no write.
- The state machine has two states, IDLE and CLEAR.
  - In IDLE, flush_req moves to CLEAR with ptr=0.
  - In CLEAR, entry[ptr] is cleared each cycle (valid=0, ctr=2'b01) and ptr increments.
  - CLEAR returns to IDLE after clearing entry ENTRIES-1.
- bp_busy = (state == CLEAR).

## Timing
- Reset clears all valid bits, sets every counter to 2'b01, sets the state to IDLE and ptr=0, and zeroes both stat counters.
  - Outputs after reset: pred_taken=0, bp_busy=0, mispredict=0.
- Prediction latency is 0 cycles; training is visible on the cycle after the resolve edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update state.
- flush_req sampled at edge N: bp_busy is high for exactly ENTRIES cycles, from after edge N until edge N+ENTRIES.
- flush_req while in CLEAR restarts the sweep at ptr=0.
- Training is suppressed during CLEAR and in the cycle flush_req is sampled. Mispredict and redirect outputs remain valid throughout.
- An asynchronous reset mid-sweep aborts to IDLE with all entries cleared.

## Configuration
- BRANCH_PREDICTOR_STATS_EN defined:
  - stat_branches increments on each resolve.
  - stat_mispredicts increments on each resolve with mispredict=1.
  - Both saturate at 32'hFFFF_FFFF. flush_req does not clear them.
- Macro undefined: both stat outputs are tied to 0 and no counter logic is built.

## Test plan
- Reset, then if_pc=0x1000 -> pred_taken=0, pred_target=0x1004, bp_busy=0.
- Resolve ex_pc=0x1000, taken, ex_target=0x2000, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x2000. Next cycle if_pc=0x1000 -> pred_taken=1, pred_target=0x2000.
- After that allocation, resolve 0x1000 not-taken once (counter 10 -> 01) -> pred_taken=0. Resolve taken once (01 -> 10) -> pred_taken=1, with no new allocation.
- Alias with ENTRIES=64: 0x1000 is allocated, then if_pc=0x1100 (same index, different tag) -> pred_taken=0, pred_target=0x1104.
- Pulse flush_req with an ex taken-resolve in the same cycle -> bp_busy high for 64 cycles and pred_taken=0 throughout. Afterwards 0x1000 misses and the resolve left no entry.
- With BRANCH_PREDICTOR_STATS_EN defined: 10 resolves with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. Values are unchanged by a flush and zero after rst.
